// File: rtl/vga_tile_mem_arbiter_if.sv
// vga_tile_mem_arbiter_if: VGA timing, CPU request and tile RAM signals around the arbiter.
interface vga_tile_mem_arbiter_if #(parameter int DATA_W = 16, parameter int ADDR_W = 13);
  logic              enable;
  logic              bright;
  logic [10:0]       hCount;
  logic [10:0]       vCount;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (input enable, bright, hCount, vCount, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
                 output disp_data, disp_valid, cpu_rdata, cpu_ack, mem_en, mem_we, mem_addr, mem_wdata);
  modport master (output enable, bright, hCount, vCount, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
                  input disp_data, disp_valid, cpu_rdata, cpu_ack, mem_en, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/vga_tile_mem_arbiter.sv
// vga_tile_mem_arbiter: shares a single-port tile RAM between VGA display fetch and a CPU port.
// Define CPU_VBLANK_ONLY_EN to restrict CPU accesses to blanking (bright==0).
module vga_tile_mem_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 13,
  parameter int COLS       = 80,
  parameter int TILE_SHIFT = 3,
  parameter int BASE_ADDR  = 0
) (
  input logic                   i_clk,
  input logic                   i_clear_n,
  vga_tile_mem_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, DISP_RD, CPU_RD, CPU_WR, CPU_RESP} state_t;
  state_t              r_state, w_next;
  logic                w_disp, w_cpu;
  logic [ADDR_W-1:0]   w_disp_addr;
  logic                r_busy, r_disp_p, r_rd_p;
  logic                r_mem_en, r_mem_we, r_disp_valid, r_cpu_ack;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata, r_disp_data, r_cpu_rdata;
  assign w_disp_addr = ADDR_W'(32'(BASE_ADDR) + 32'(bus.vCount >> TILE_SHIFT) * 32'(COLS)
                               + 32'(bus.hCount >> TILE_SHIFT));
  always_comb begin
    w_disp = bus.enable & bus.bright & (bus.hCount[TILE_SHIFT-1:0] == '0);
`ifdef CPU_VBLANK_ONLY_EN
    w_cpu = ~w_disp & bus.cpu_req & ~r_busy & ~bus.bright;
`else
    w_cpu = ~w_disp & bus.cpu_req & ~r_busy;
`endif
    w_next = w_disp ? DISP_RD : w_cpu ? (bus.cpu_we ? CPU_WR : CPU_RD) : (r_state == CPU_RD) ? CPU_RESP : IDLE;
  end
  // Read data lands one cycle after the RAM's address edge, hence the *_p pipeline flags.
  always_ff @(posedge i_clk or negedge i_clear_n) begin
    if (!i_clear_n) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_disp_p     <= 1'b0;
      r_rd_p       <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_disp_valid <= 1'b0;
      r_disp_data  <= '0;
      r_cpu_ack    <= 1'b0;
      r_cpu_rdata  <= '0;
    end else begin
      r_state      <= w_next;
      r_mem_en     <= w_disp | w_cpu;
      r_mem_we     <= w_cpu & bus.cpu_we;
      r_mem_addr   <= w_disp ? w_disp_addr : w_cpu ? bus.cpu_addr : r_mem_addr;
      r_mem_wdata  <= (w_cpu & bus.cpu_we) ? bus.cpu_wdata : r_mem_wdata;
      r_busy       <= w_cpu | (r_busy & ~r_cpu_ack);
      r_disp_p     <= r_state == DISP_RD;
      r_disp_valid <= r_disp_p;
      r_disp_data  <= r_disp_p ? bus.mem_rdata : r_disp_data;
      r_rd_p       <= r_state == CPU_RD;
      r_cpu_ack    <= (r_state == CPU_WR) | r_rd_p;
      r_cpu_rdata  <= r_rd_p ? bus.mem_rdata : r_cpu_rdata;
    end
  end
  assign bus.mem_en     = r_mem_en;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.disp_valid = r_disp_valid;
  assign bus.disp_data  = r_disp_data;
  assign bus.cpu_ack    = r_cpu_ack;
  assign bus.cpu_rdata  = r_cpu_rdata;
endmodule

// File: tb/tb_vga_tile_mem_arbiter.sv
// tb_vga_tile_mem_arbiter: randomized checks of display fetch, CPU access and arbitration
// against a shadow-memory model; a second instance with BASE_ADDR=8000 checks address wrap.
module tb_vga_tile_mem_arbiter;
  localparam int DW = 16;
  localparam int AW = 13;
  logic clk = 1'b0;
  logic clear_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [DW-1:0] ram     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  always #5 clk = ~clk;
  vga_tile_mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  vga_tile_mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();
  vga_tile_mem_arbiter dut (.i_clk(clk), .i_clear_n(clear_n), .bus(bus.slave));
  vga_tile_mem_arbiter #(.BASE_ADDR(8000)) dut2 (.i_clk(clk), .i_clear_n(clear_n), .bus(bus2.slave));
  assign bus2.enable    = bus.enable;
  assign bus2.bright    = bus.bright;
  assign bus2.hCount    = bus.hCount;
  assign bus2.vCount    = bus.vCount;
  assign bus2.cpu_req   = 1'b0;
  assign bus2.cpu_we    = 1'b0;
  assign bus2.cpu_addr  = '0;
  assign bus2.cpu_wdata = '0;
  assign bus2.mem_rdata = '0;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
    end
  end
  function automatic logic [AW-1:0] exp_addr(int base, int h, int v);
    return AW'((base + (v / 8) * 80 + h / 8) % 8192);
  endfunction
  task automatic cpu_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit mix,
                        output logic [DW-1:0] rd, output int lat);
    bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_req = 1'b1;
    lat = 0; rd = '0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      if (mix) begin
        bus.enable = i[0]; bus.bright = i[0];
        bus.hCount = 11'($urandom_range(0, 79) * 8 + ($urandom_range(0, 1) != 0 ? 0 : 5));
        bus.vCount = 11'($urandom_range(0, 479));
      end
      @(negedge clk);
      if (bus.cpu_ack === 1'b1) begin lat = i; rd = bus.cpu_rdata; end
    end
    bus.cpu_req = 1'b0; bus.enable = 1'b0; bus.bright = 1'b0;
    if (we && lat != 0) ref_mem[a] = d;
    @(negedge clk);
  endtask
  task automatic test_reset;
    bus.enable = 0; bus.bright = 0; bus.hCount = '0; bus.vCount = '0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    clear_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.disp_data, bus.disp_valid, bus.cpu_rdata, bus.cpu_ack, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0) begin
      n_err++; $display("FAIL reset_outputs got=%h exp=0", {bus.disp_data, bus.disp_valid, bus.cpu_rdata, bus.cpu_ack, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata});
    end
    clear_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_cpu;
    logic [DW-1:0] rd, d;
    logic [AW-1:0] a;
    int lat;
    for (int k = 0; k < 8; k++) begin
      a = (k == 0) ? AW'(13'h100) : AW'($urandom);
      d = (k == 0) ? DW'(16'hBEEF) : DW'($urandom);
      cpu_op(1'b1, a, d, 1'b0, rd, lat);
      n_cmp++;
      if (lat !== 2) begin n_err++; $display("FAIL cpu_wr_latency got=%0d exp=2", lat); end
      if (k[0]) a = AW'($urandom);
      cpu_op(1'b0, a, '0, 1'b0, rd, lat);
      n_cmp++;
      if (lat !== 3 || rd !== ref_mem[a]) begin
        n_err++; $display("FAIL cpu_rd addr=%h got lat=%0d data=%h exp lat=3 data=%h", a, lat, rd, ref_mem[a]);
      end
    end
  endtask
  task automatic test_disp;
    int h, v;
    logic [AW-1:0] ea;
    for (int k = 0; k < 10; k++) begin
      h = (k == 0) ? 16 : (k == 1) ? 632 : 8 * $urandom_range(0, 79);
      v = (k == 0) ? 8 : (k == 1) ? 472 : $urandom_range(0, 479);
      ea = exp_addr(0, h, v);
      bus.hCount = 11'(h); bus.vCount = 11'(v); bus.enable = 1; bus.bright = 1;
      @(negedge clk);
      bus.enable = 0;
      n_cmp++;
      if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== ea) begin
        n_err++; $display("FAIL disp_issue h=%0d v=%0d got en=%b we=%b addr=%0d exp en=1 we=0 addr=%0d", h, v, bus.mem_en, bus.mem_we, bus.mem_addr, ea);
      end
      n_cmp++;
      if (bus2.mem_addr !== exp_addr(8000, h, v)) begin
        n_err++; $display("FAIL disp_wrap_addr got=%0d exp=%0d", bus2.mem_addr, exp_addr(8000, h, v));
      end
      @(negedge clk);
      n_cmp++;
      if (bus.disp_valid !== 1'b0) begin n_err++; $display("FAIL disp_valid_early got=%b exp=0", bus.disp_valid); end
      @(negedge clk);
      n_cmp++;
      if (bus.disp_valid !== 1'b1 || bus.disp_data !== ref_mem[ea]) begin
        n_err++; $display("FAIL disp_data got v=%b d=%h exp v=1 d=%h", bus.disp_valid, bus.disp_data, ref_mem[ea]);
      end
      bus.hCount = 11'(h + 3); bus.enable = 1;
      @(negedge clk);
      bus.enable = 0;
      n_cmp++;
      if (bus.mem_en !== 1'b0 || bus.disp_valid !== 1'b0) begin
        n_err++; $display("FAIL disp_unaligned got en=%b valid=%b exp 0 0", bus.mem_en, bus.disp_valid);
      end
      @(negedge clk);
      bus.hCount = 11'(h); bus.enable = 1; bus.bright = 0;
      @(negedge clk);
      bus.enable = 0;
      n_cmp++;
      if (bus.mem_en !== 1'b0) begin n_err++; $display("FAIL disp_not_bright got en=%b exp 0", bus.mem_en); end
      @(negedge clk);
    end
  endtask
  task automatic test_collision;
    logic [AW-1:0] a, ea;
    logic [DW-1:0] d, rd;
    int h, v, lat;
    for (int k = 0; k < 4; k++) begin
      h = 8 * $urandom_range(0, 79); v = $urandom_range(0, 479);
      ea = exp_addr(0, h, v); a = AW'($urandom); d = DW'($urandom);
      bus.hCount = 11'(h); bus.vCount = 11'(v); bus.enable = 1; bus.bright = 1;
      bus.cpu_we = 1; bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_req = 1;
      @(negedge clk);
      bus.enable = 0; bus.bright = 0;
      n_cmp++;
      if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== ea) begin
        n_err++; $display("FAIL collide_disp_first got en=%b we=%b addr=%0d exp 1 0 %0d", bus.mem_en, bus.mem_we, bus.mem_addr, ea);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.mem_we !== 1'b1 || bus.mem_addr !== a || bus.mem_wdata !== d) begin
        n_err++; $display("FAIL collide_cpu_next got we=%b addr=%h wd=%h exp 1 %h %h", bus.mem_we, bus.mem_addr, bus.mem_wdata, a, d);
      end
      @(negedge clk);
      bus.cpu_req = 0;
      n_cmp++;
      if (bus.cpu_ack !== 1'b1 || bus.disp_valid !== 1'b1 || bus.disp_data !== ref_mem[ea]) begin
        n_err++; $display("FAIL collide_ack got ack=%b valid=%b d=%h exp 1 1 %h", bus.cpu_ack, bus.disp_valid, bus.disp_data, ref_mem[ea]);
      end
      ref_mem[a] = d;
      @(negedge clk);
      cpu_op(1'b0, a, '0, 1'b0, rd, lat);
      n_cmp++;
      if (rd !== d) begin n_err++; $display("FAIL collide_readback got=%h exp=%h", rd, d); end
    end
  endtask
  task automatic test_back_to_back;
    logic [AW-1:0] a;
    logic [DW-1:0] d, rd;
    logic we;
    int lat;
    for (int k = 0; k < 16; k++) begin
      we = 1'($urandom_range(0, 1)); a = AW'($urandom_range(0, 15)); d = DW'($urandom);
      cpu_op(we, a, d, 1'b1, rd, lat);
      n_cmp++;
      if (lat < 2 || lat > 4 || (!we && rd !== ref_mem[a])) begin
        n_err++; $display("FAIL mix_op we=%b addr=%h got lat=%0d rd=%h exp lat 2..4 rd=%h", we, a, lat, rd, ref_mem[a]);
      end
    end
  endtask
  task automatic test_reset_mid;
    bus.cpu_we = 0; bus.cpu_addr = AW'($urandom); bus.cpu_req = 1;
    @(negedge clk);
    n_cmp++;
    if (bus.mem_en !== 1'b1) begin n_err++; $display("FAIL mid_rd_issue got en=%b exp 1", bus.mem_en); end
    #2 clear_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.disp_data, bus.disp_valid, bus.cpu_rdata, bus.cpu_ack, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0) begin
      n_err++; $display("FAIL mid_reset_outputs got=%h exp=0", {bus.disp_data, bus.disp_valid, bus.cpu_rdata, bus.cpu_ack, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata});
    end
    bus.cpu_req = 0;
    @(negedge clk);
    clear_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.cpu_ack !== 1'b0 || bus.mem_en !== 1'b0) begin
        n_err++; $display("FAIL mid_reset_no_ack cyc=%0d got ack=%b en=%b exp 0 0", i, bus.cpu_ack, bus.mem_en);
      end
    end
  endtask
  task automatic test_vblank;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int lat;
    a = AW'($urandom); d = DW'($urandom); lat = 0;
    bus.enable = 0; bus.bright = 1;
    bus.cpu_we = 1; bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_req = 1;
`ifdef CPU_VBLANK_ONLY_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.mem_en !== 1'b0 || bus.cpu_ack !== 1'b0) begin
        n_err++; $display("FAIL vblank_stall got en=%b ack=%b exp 0 0", bus.mem_en, bus.cpu_ack);
      end
    end
    bus.bright = 0;
`endif
    for (int i = 1; i <= 4 && lat == 0; i++) begin
      @(negedge clk);
      if (bus.cpu_ack === 1'b1) lat = i;
    end
    bus.cpu_req = 0; bus.bright = 0;
    n_cmp++;
    if (lat != 2) begin n_err++; $display("FAIL bright_cpu_ack got lat=%0d exp=2", lat); end
    ref_mem[a] = d;
    @(negedge clk);
    n_cmp++;
    if (ram[a] !== d) begin n_err++; $display("FAIL bright_cpu_write got=%h exp=%h", ram[a], d); end
  endtask
  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = DW'($urandom);
      ref_mem[i] = ram[i];
    end
    test_reset;
    test_cpu;
    test_disp;
    test_collision;
    test_back_to_back;
    test_reset_mid;
    test_vblank;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
